mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipelined ARM core's fetch port (Fetch stage) and data port (Memory stage).
- Sits between `arm` and the memory model.
- Serialises requests, holds address/data stable for the memory, and returns read data with a one-cycle valid pulse.
- Stall, starvation and timeout handling are done here so the core's hazard logic only consumes `StallF`/`StallM`.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/arb_timeout_counter.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified-memory port
//               arbiter (state encoding, owner encoding, abort data).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter state: who, if anyone, currently owns the memory
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  // Requester that an in-flight access belongs to
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Read data returned to the requester when an access is aborted
  localparam logic [31:0] ERR_DATA        = 32'hDEADBEEF;
  localparam int          DEF_MAX_DSTREAK = 4;
  localparam int          DEF_TIMEOUT     = 64;

endpackage
`default_nettype wire

// File: rtl/arb_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_timeout_counter
// Description : Loadable down-counter. Loaded with TIMEOUT-1 when an access
//               starts, counts down while the access is in flight and flags
//               expiry in the last cycle the memory is allowed to take.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_timeout_counter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_LOAD_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Reload on access start, otherwise count down to zero and hold there
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_LOAD_VAL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between the core's fetch and
//               data ports. Serialises requests, latches the owner's address
//               and data for the memory, returns read data with a one-cycle
//               valid pulse, limits data-port starvation of fetches and
//               aborts accesses the memory never completes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  // Fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  // Data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  // Hazard unit stalls
  output logic              StallF,
  output logic              StallM,
  // Memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int               STK_W     = $clog2(MAX_DSTREAK + 1);
  localparam logic [STK_W-1:0] c_STK_MAX = STK_W'(MAX_DSTREAK);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [STK_W-1:0]  r_streak;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_i_valid;
  logic              r_d_valid;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_err;

  logic              w_start_i;
  logic              w_start_d;
  logic              w_finish;
  logic              w_abort;
  logic              w_expire;
  owner_t            w_owner;
  logic [DATA_W-1:0] w_rsp_data;

  // Watchdog for the access in flight; cleared on every grant
  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_start_i | w_start_d),
    .i_en     (r_state != IDLE),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: grant in IDLE, complete or abort while busy
  always_comb begin
    w_next_state = r_state;
    w_start_i    = 1'b0;
    w_start_d    = 1'b0;
    w_finish     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        // Data wins ties until it has starved a waiting fetch long enough
        if (i_req && (!d_req || (r_streak == c_STK_MAX))) begin
          w_next_state = BUSY_I;
          w_start_i    = 1'b1;
        end else if (d_req) begin
          w_next_state = BUSY_D;
          w_start_d    = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        // A completion in the final allowed cycle still counts as success
        if (mem_ready) begin
          w_next_state = IDLE;
          w_finish     = 1'b1;
        end else if (w_expire) begin
          w_next_state = IDLE;
          w_abort      = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_owner    = (r_state == BUSY_D) ? OWN_D : OWN_I;
  assign w_rsp_data = w_abort  ? DATA_W'(ERR_DATA) :
                      r_mem_we ? '0 : mem_rdata;

  // Consecutive data grants made while a fetch was waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_streak <= '0;
    end else if (w_start_i) begin
      r_streak <= '0;
    end else if (w_start_d) begin
      if (!i_req) begin
        r_streak <= '0;
      end else if (r_streak != c_STK_MAX) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

  // Memory-side latches and requester-side completion registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_valid   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_err     <= 1'b0;
      if (w_start_i || w_start_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_start_d & d_we;
        r_mem_addr  <= w_start_d ? d_addr : i_addr;
        r_mem_wdata <= w_start_d ? d_wdata : '0;
      end else if (w_finish || w_abort) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        r_err     <= w_abort;
        if (w_owner == OWN_D) begin
          r_d_valid <= 1'b1;
          r_d_rdata <= w_rsp_data;
        end else begin
          r_i_valid <= 1'b1;
          r_i_rdata <= w_rsp_data;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_valid   = r_i_valid;
  assign d_valid   = r_d_valid;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;
  assign StallF    = i_req & ~r_i_valid;
  assign StallM    = d_req & ~r_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: a vector table of
//               single transfers, hand-written contention, starvation,
//               reset and stray-ready sequences, and a per-port scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_valid;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          StallF;
  logic          StallM;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_DSTREAK (4),
    .TIMEOUT     (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_valid   (i_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .StallF    (StallF),
    .StallM    (StallM),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  typedef struct {
    bit            port_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rsp;
    int            lat;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_cyc;
  } vec_t;

  exp_t exp_i_q[$];
  exp_t exp_d_q[$];
  vec_t vecs[10];

  int checks = 0;
  int errors = 0;

  // Memory model controls and observations
  int            lat = 1;
  logic [DW-1:0] rsp_data = '0;
  int            busy_cnt = 0;
  int            stab_err = 0;
  int            stray_n = 0;
  logic [AW-1:0] cap_addr = '0;
  logic          cap_we = 1'b0;
  logic [DW-1:0] cap_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: answers after 'lat' busy cycles (0 = never), records
  // the latched request and notices any change while the access is open
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (mem_req) begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          cap_addr  = mem_addr;
          cap_we    = mem_we;
          cap_wdata = mem_wdata;
        end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
          stab_err++;
        end
        if (lat != 0 && busy_cnt == lat) begin
          mem_ready = 1'b1;
          mem_rdata = rsp_data;
        end
      end else begin
        busy_cnt = 0;
        if (stray_n > 0) begin
          mem_ready = 1'b1;
          mem_rdata = 32'h1234_5678;
          stray_n--;
        end
      end
    end
  end

  // Scoreboard and per-cycle invariants
  initial begin
    forever begin
      @(negedge clk);
      check("StallF", StallF, i_req & ~i_valid);
      check("StallM", StallM, d_req & ~d_valid);
      if (i_valid && d_valid) check("valid_overlap", 1, 0);
      if (err && !(i_valid || d_valid)) check("err_without_valid", 1, 0);
      if (i_valid) begin
        exp_t e;
        if (exp_i_q.size() == 0) begin
          check("i_valid_unexpected", 1, 0);
        end else begin
          e = exp_i_q.pop_front();
          check("i_rdata", i_rdata, e.data);
          check("i_err", err, e.err);
        end
      end
      if (d_valid) begin
        exp_t e;
        if (exp_d_q.size() == 0) begin
          check("d_valid_unexpected", 1, 0);
        end else begin
          e = exp_d_q.pop_front();
          check("d_rdata", d_rdata, e.data);
          check("d_err", err, e.err);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // One transfer from a table row; requester inputs are scrambled while busy
  task automatic do_xfer(input vec_t v, input int idx);
    int   n;
    bit   done;
    exp_t e;
    lat       = v.lat;
    rsp_data  = v.rsp;
    e.data    = v.exp_rdata;
    e.err     = v.exp_err;
    if (v.port_d) begin
      exp_d_q.push_back(e);
      d_req   = 1'b1;
      d_we    = v.we;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end else begin
      exp_i_q.push_back(e);
      i_req  = 1'b1;
      i_addr = v.addr;
    end
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      cycle();
      n++;
      if (v.port_d ? d_valid : i_valid) begin
        done = 1'b1;
      end else begin
        i_addr  = ~i_addr;
        d_addr  = ~d_addr;
        d_wdata = d_wdata + 1;
        d_we    = ~d_we;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check($sformatf("v%0d_done", idx), done, 1);
    check($sformatf("v%0d_cycles", idx), n, v.exp_cyc);
    check($sformatf("v%0d_mem_addr", idx), cap_addr, v.addr);
    check($sformatf("v%0d_mem_we", idx), cap_we, v.port_d & v.we);
    if (v.port_d && v.we) check($sformatf("v%0d_mem_wdata", idx), cap_wdata, v.wdata);
    cycle();
  endtask

  // Fetch held while the data port re-requests every idle cycle
  task automatic run_starve(input logic [AW-1:0] base, input int tag);
    int   n;
    int   dc;
    int   db;
    bit   fd;
    bit   df;
    exp_t e;
    lat      = 1;
    rsp_data = 32'h600D_D00D;
    e.data   = 32'h600D_D00D;
    e.err    = 1'b0;
    exp_i_q.push_back(e);
    exp_d_q.push_back(e);
    i_req  = 1'b1;
    i_addr = 32'h100;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = base;
    n  = 0;
    dc = 0;
    db = -1;
    fd = 1'b0;
    df = 1'b0;
    while (!(fd && df) && n < 100) begin
      cycle();
      n++;
      if (i_valid) begin
        fd    = 1'b1;
        db    = dc;
        i_req = 1'b0;
      end
      if (d_valid) begin
        dc++;
        if (!fd) begin
          d_addr = d_addr + 4;
          exp_d_q.push_back(e);
        end else begin
          d_req = 1'b0;
          df    = 1'b1;
        end
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check($sformatf("starve%0d_done", tag), fd & df, 1);
    check($sformatf("starve%0d_data_before_fetch", tag), db, 4);
    check($sformatf("starve%0d_data_total", tag), dc, 5);
    cycle();
  endtask

  initial begin
    int   n;
    int   dc;
    int   ic;
    int   vcount;
    bit   dn;
    bit   fn;
    exp_t e;
    vec_t v;

    reset   = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;

    //          port we  addr          wdata         rsp           lat exp_rdata     err cyc
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,        32'hE3A0_0001, 2,  32'hE3A0_0001, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 1,  32'hCAFE_F00D, 1'b0, 2};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h5,        32'h1111_1111, 1,  32'h0,         1'b0, 2};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_000C, 32'h0,        32'hE1A0_0000, 4,  32'hE1A0_0000, 1'b0, 5};
    vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hAAAA_5555, 3,  32'h0,         1'b0, 4};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        32'h0BAD_0BAD, 0,  32'hDEAD_BEEF, 1'b1, 65};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'h0BAD_0BAD, 0,  32'hDEAD_BEEF, 1'b1, 65};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,        32'h0,         1,  32'h0,         1'b0, 2};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,        32'h7654_3210, 64, 32'h7654_3210, 1'b0, 65};
    vecs[9] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_0001, 1,  32'h0000_0001, 1'b0, 2};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {mem_req, mem_we, i_valid, d_valid, err}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    reset = 1'b1;
    cycle();

    for (int k = 0; k < 10; k++) begin
      do_xfer(vecs[k], k);
    end

    // Both ports request together: data first, fetch after the gap cycle
    lat      = 1;
    rsp_data = 32'h0BAD_C0DE;
    e.data   = 32'h0;
    e.err    = 1'b0;
    exp_d_q.push_back(e);
    e.data   = 32'h0BAD_C0DE;
    exp_i_q.push_back(e);
    i_req   = 1'b1;
    i_addr  = 32'h40;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'h5;
    cycle();
    check("sim_mem_req", mem_req, 1);
    check("sim_mem_we", mem_we, 1);
    check("sim_mem_addr", mem_addr, 32'h20);
    check("sim_mem_wdata", mem_wdata, 32'h5);
    n  = 1;
    dn = 1'b0;
    fn = 1'b0;
    dc = 0;
    ic = 0;
    while (!(dn && fn) && n < 50) begin
      cycle();
      n++;
      if (d_valid) begin
        dn    = 1'b1;
        dc    = n;
        d_req = 1'b0;
      end
      if (i_valid) begin
        fn    = 1'b1;
        ic    = n;
        i_req = 1'b0;
      end
    end
    check("sim_done", dn & fn, 1);
    check("sim_d_cycle", dc, 2);
    check("sim_i_cycle", ic, 4);
    cycle();

    run_starve(32'h200, 0);
    run_starve(32'h300, 1);

    // Asynchronous reset while a fetch is waiting on the memory
    lat    = 0;
    i_req  = 1'b1;
    i_addr = 32'h80;
    cycle();
    cycle();
    cycle();
    check("rma_busy", mem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rma_ctrl", {mem_req, mem_we, i_valid, d_valid, err}, 0);
    check("rma_mem_addr", mem_addr, 0);
    check("rma_mem_wdata", mem_wdata, 0);
    check("rma_rdata", {i_rdata, d_rdata}, 0);
    i_req = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    v = '{1'b1, 1'b0, 32'h0000_0050, 32'h0, 32'h1357_9BDF, 2, 32'h1357_9BDF, 1'b0, 3};
    do_xfer(v, 10);

    // Ready pulses with nothing in flight must be ignored
    stray_n = 2;
    vcount  = 0;
    repeat (6) begin
      cycle();
      if (i_valid || d_valid || err || mem_req) vcount++;
    end
    check("stray_no_activity", vcount, 0);
    check("hold_d_rdata", d_rdata, 32'h1357_9BDF);
    check("hold_i_rdata", i_rdata, 32'h0);

    check("mem_stable_while_busy", stab_err, 0);
    check("exp_i_drained", exp_i_q.size(), 0);
    check("exp_d_drained", exp_d_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
